aclk_controller: RTL and testbench
==================================

# aclk_controller

Sequencing FSM for the alarm-clock display path. It decodes the keypad code and captures up to four entered digits in a key buffer. It drives the display driver's `show_a` / `show_new_time` selects and emits single-cycle `load_new_a` / `load_new_c` strobes so the alarm register or the time counter is loaded from the buffer. It sits between the keypad scanner and the display driver, alarm register and time counter.

## Interface
- `TIMEOUT_S`, default 10: number of `one_second` pulses without a key in KEY_ENTRY before entry is abandoned; legal range 1..15.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `one_second`  in  1  one-cycle tick, once per second.
- `key`  in  4  keypad code:
  - 0..9 are digits.
  - 4'hA is ALARM.
  - 4'hB is TIME.
  - 4'hF is NOKEY.
  - 4'hC..4'hE are treated as NOKEY.
- `key_buffer`  out  16  four BCD digits; [3:0] is the newest digit.
- `show_a`  out  1  display selects the alarm time.
- `show_new_time`  out  1  display selects the key buffer.
- `load_new_a`  out  1  one-cycle strobe: alarm register loads `key_buffer`.
- `load_new_c`  out  1  one-cycle strobe: time counter loads `key_buffer`.

## Operation
- **States:** SHOW_TIME, SHOW_ALARM, KEY_WAITED, KEY_ENTRY, WAIT_RELEASE.
- **SHOW_TIME:**
  - Digit: `key_buffer <= {12'h000, key}`, go to KEY_WAITED.
  - ALARM: go to SHOW_ALARM.
  - TIME or NOKEY: stay.
- **SHOW_ALARM:** NOKEY goes to SHOW_TIME; any other code stays.
- **KEY_WAITED** (waits for key release): NOKEY goes to KEY_ENTRY and clears the timeout count; otherwise stay.
- **KEY_ENTRY:**
  - Digit: `key_buffer <= {key_buffer[11:0], key}`; the oldest digit is dropped; go to KEY_WAITED.
  - ALARM: `load_new_a` pulse, go to WAIT_RELEASE.
  - TIME: `load_new_c` pulse, go to WAIT_RELEASE.
  - NOKEY with `one_second`: the timeout count increments. When the count reaches `TIMEOUT_S`, go to SHOW_TIME with no load; the buffer is kept.
- **WAIT_RELEASE:** NOKEY goes to SHOW_TIME. This prevents a held ALARM key re-entering SHOW_ALARM.
- **Output decode** (Moore, from the state register):
  - `show_a` = SHOW_ALARM.
  - `show_new_time` = KEY_WAITED or KEY_ENTRY.
- **Timeout count:** 4 bits, saturating, meaningful only in KEY_ENTRY.

## Timing
- **Reset values:**
  - state SHOW_TIME.
  - `key_buffer` 16'h0000.
  - timeout count 0.
  - `show_a`, `show_new_time`, `load_new_a`, `load_new_c` all 0.
- Key sampled at edge N updates state and `key_buffer` at edge N; selects change in cycle N+1.
- `load_new_a` / `load_new_c`:
  - Registered and high for exactly the first cycle of WAIT_RELEASE, one cycle after ALARM/TIME is sampled.
  - `key_buffer` is stable during the strobe.
- **Simultaneous events:**
  - In KEY_ENTRY, digit/ALARM/TIME beats a coincident `one_second`; the count is not incremented.
  - A digit in the same cycle as the timeout-reaching tick wins.
- A key held indefinitely in KEY_WAITED or SHOW_ALARM holds the state; there is no timeout there.
- A fifth and later digit shifts out the oldest; there is no overflow flag.
- **Reset mid-operation:**
  - Immediate return to SHOW_TIME with the buffer cleared.
  - A pending or in-flight load strobe is dropped, never stretched.

## Configuration
- `ACLK_TIMEOUT_EN`:
  - **Defined:** the KEY_ENTRY timeout counter and `TIMEOUT_S` are active as described.
  - **Undefined:** the counter is not built; `one_second` is ignored; KEY_ENTRY persists until ALARM, TIME or a digit. All other behaviour is identical.

## Structure
- Package `aclk_pkg`:
  - key codes KEY_ALARM = 4'hA, KEY_TIME = 4'hB, KEY_NONE = 4'hF.
  - `is_digit` helper.
  - state typedef.
- Sub-module `aclk_key_buffer`:
  - 16-bit shift register.
  - Inputs `clear_load` (load `{12'h0, digit}`) and `shift`.
  - Asynchronous active-low reset.
  - The FSM drives its strobes.

## Test plan
- Reset, then key F for 5 cycles: state SHOW_TIME; all selects and strobes 0; `key_buffer` 16'h0000.
- Keys 1,F,2,F,3,F,0,F then A: `key_buffer` 16'h1230; `load_new_a` high for one cycle after A is sampled; `show_new_time` 1 during entry; SHOW_TIME after release.
- Keys 5,F,9,F then B held 4 cycles then F: `key_buffer` 16'h0059; one `load_new_c` pulse only; no SHOW_ALARM entry.
- A held 3 cycles then F: `show_a` 1 for 3 cycles, then 0; no strobes.
- Keys 1..6 with releases: `key_buffer` 16'h3456.
- `ACLK_TIMEOUT_EN` with `TIMEOUT_S`=3:
  - Digit 7, release, 3 `one_second` ticks: return to SHOW_TIME with no strobe.
  - `rst_n` low in the strobe cycle: strobe deasserted immediately.

Source files
------------

// File: rtl/aclk_pkg.sv
// Shared key codes, state encoding and key classification helpers for the alarm-clock sequencer.
package aclk_pkg;

    localparam logic [3:0] KEY_ALARM = 4'hA;
    localparam logic [3:0] KEY_TIME  = 4'hB;
    localparam logic [3:0] KEY_NONE  = 4'hF;

    typedef logic [2:0] state_t;

    localparam state_t ST_SHOW_TIME    = 3'd0;
    localparam state_t ST_SHOW_ALARM   = 3'd1;
    localparam state_t ST_KEY_WAITED   = 3'd2;
    localparam state_t ST_KEY_ENTRY    = 3'd3;
    localparam state_t ST_WAIT_RELEASE = 3'd4;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    // Codes 4'hC..4'hE are unused on the keypad and behave like no key at all.
    function automatic logic is_none(input logic [3:0] k);
        return !is_digit(k) && (k != KEY_ALARM) && (k != KEY_TIME);
    endfunction

endpackage

// File: rtl/aclk_key_buffer.sv
// Four-digit BCD entry buffer; newest digit in [3:0], oldest digit drops off the top.
module aclk_key_buffer
    import aclk_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_load,
    input  logic        shift,
    input  logic [3:0]  digit,
    output logic [15:0] key_buffer
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_buffer <= 16'h0000;
        end else if (clear_load) begin
            key_buffer <= {12'h000, digit};
        end else if (shift) begin
            key_buffer <= {key_buffer[11:0], digit};
        end
    end

endmodule

// File: rtl/aclk_controller.sv
// Alarm-clock display sequencer: keypad decode, digit entry, alarm/time load strobes.
// Optional KEY_ENTRY inactivity timeout is built when ACLK_TIMEOUT_EN is defined.
//
// state           | meaning
// ST_SHOW_TIME    | idle, display shows the running time
// ST_SHOW_ALARM   | ALARM held, display shows the alarm time
// ST_KEY_WAITED   | digit captured, waiting for key release
// ST_KEY_ENTRY    | released, waiting for next digit / ALARM / TIME
// ST_WAIT_RELEASE | load strobe issued, waiting for ALARM/TIME release
module aclk_controller
    import aclk_pkg::*;
#(
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        one_second,
    input  logic [3:0]  key,
    output logic [15:0] key_buffer,
    output logic        show_a,
    output logic        show_new_time,
    output logic        load_new_a,
    output logic        load_new_c
);

    state_t state;
    state_t next_state;
    logic   clear_load;
    logic   shift;
    logic   go_a;
    logic   go_c;
    logic   cnt_clr;
    logic   timeout_hit;

`ifdef ACLK_TIMEOUT_EN
    logic [3:0] timeout_cnt;
    logic       tick_idle;

    assign tick_idle   = (state == ST_KEY_ENTRY) && is_none(key) && one_second;
    assign timeout_hit = tick_idle && (({1'b0, timeout_cnt} + 5'd1) >= 5'(TIMEOUT_S));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt <= 4'd0;
        end else if (cnt_clr) begin
            timeout_cnt <= 4'd0;
        end else if (tick_idle && (timeout_cnt != 4'hF)) begin
            timeout_cnt <= timeout_cnt + 4'd1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^{one_second, cnt_clr, 4'(TIMEOUT_S)};
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        next_state = state;
        clear_load = 1'b0;
        shift      = 1'b0;
        go_a       = 1'b0;
        go_c       = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            ST_SHOW_TIME: begin
                if (is_digit(key)) begin
                    clear_load = 1'b1;
                    next_state = ST_KEY_WAITED;
                end else if (key == KEY_ALARM) begin
                    next_state = ST_SHOW_ALARM;
                end
            end
            ST_SHOW_ALARM: begin
                if (is_none(key)) next_state = ST_SHOW_TIME;
            end
            ST_KEY_WAITED: begin
                if (is_none(key)) begin
                    cnt_clr    = 1'b1;
                    next_state = ST_KEY_ENTRY;
                end
            end
            ST_KEY_ENTRY: begin
                // Any real key outranks a coincident one_second tick.
                if (is_digit(key)) begin
                    shift      = 1'b1;
                    next_state = ST_KEY_WAITED;
                end else if (key == KEY_ALARM) begin
                    go_a       = 1'b1;
                    next_state = ST_WAIT_RELEASE;
                end else if (key == KEY_TIME) begin
                    go_c       = 1'b1;
                    next_state = ST_WAIT_RELEASE;
                end else if (timeout_hit) begin
                    next_state = ST_SHOW_TIME;
                end
            end
            ST_WAIT_RELEASE: begin
                if (is_none(key)) next_state = ST_SHOW_TIME;
            end
            default: next_state = ST_SHOW_TIME;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_SHOW_TIME;
            load_new_a <= 1'b0;
            load_new_c <= 1'b0;
        end else begin
            state      <= next_state;
            load_new_a <= go_a;
            load_new_c <= go_c;
        end
    end

    assign show_a        = (state == ST_SHOW_ALARM);
    assign show_new_time = (state == ST_KEY_WAITED) || (state == ST_KEY_ENTRY);

    aclk_key_buffer u_key_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_load (clear_load),
        .shift      (shift),
        .digit      (key),
        .key_buffer (key_buffer)
    );

endmodule

// File: tb/tb_aclk_controller.sv
// Scoreboard bench for aclk_controller: stimulus pushes per-cycle expectations from a
// digit-queue reference model, a monitor pops and compares after every rising edge.
module tb_aclk_controller;

    localparam int TS = 3;
`ifdef ACLK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] kb;
        logic        sa;
        logic        snt;
        logic        lda;
        logic        ldc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        one_second = 1'b0;
    logic [3:0]  key = 4'hF;
    logic [15:0] key_buffer;
    logic        show_a, show_new_time, load_new_a, load_new_c;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    // Reference model: a named mode plus the list of entered digits.
    typedef enum int {M_TIME, M_ALARM, M_HELD_DIGIT, M_ENTRY, M_HELD_CMD} mode_t;
    mode_t      m_mode = M_TIME;
    logic [3:0] m_digs[$];
    int         m_secs = 0;
    bit         m_lda = 0, m_ldc = 0;

    aclk_controller #(.TIMEOUT_S(TS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .one_second    (one_second),
        .key           (key),
        .key_buffer    (key_buffer),
        .show_a        (show_a),
        .show_new_time (show_new_time),
        .load_new_a    (load_new_a),
        .load_new_c    (load_new_c)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.kb = 16'h0000;
        foreach (m_digs[i]) e.kb = (e.kb << 4) | 16'(m_digs[i]);
        e.sa  = (m_mode == M_ALARM);
        e.snt = (m_mode == M_HELD_DIGIT) || (m_mode == M_ENTRY);
        e.lda = m_lda;
        e.ldc = m_ldc;
        return e;
    endfunction

    function automatic void model_reset();
        m_mode = M_TIME;
        m_digs.delete();
        m_secs = 0;
        m_lda = 0;
        m_ldc = 0;
    endfunction

    function automatic void model_step(input logic [3:0] k, input logic tick);
        bit dig, none;
        dig  = (k <= 4'd9);
        none = !dig && (k != 4'hA) && (k != 4'hB);
        m_lda = 0;
        m_ldc = 0;
        case (m_mode)
            M_TIME: begin
                if (dig) begin
                    m_digs.delete();
                    m_digs.push_back(k);
                    m_mode = M_HELD_DIGIT;
                end else if (k == 4'hA) m_mode = M_ALARM;
            end
            M_ALARM:      if (none) m_mode = M_TIME;
            M_HELD_DIGIT: if (none) begin m_mode = M_ENTRY; m_secs = 0; end
            M_ENTRY: begin
                if (dig) begin
                    m_digs.push_back(k);
                    if (m_digs.size() > 4) void'(m_digs.pop_front());
                    m_mode = M_HELD_DIGIT;
                end else if (k == 4'hA) begin
                    m_lda = 1; m_mode = M_HELD_CMD;
                end else if (k == 4'hB) begin
                    m_ldc = 1; m_mode = M_HELD_CMD;
                end else if (tick && TO_EN) begin
                    m_secs++;
                    if (m_secs >= TS) m_mode = M_TIME;
                end
            end
            M_HELD_CMD:   if (none) m_mode = M_TIME;
            default:      m_mode = M_TIME;
        endcase
    endfunction

    task automatic apply(input logic [3:0] k, input logic tick = 1'b0);
        @(negedge clk);
        key = k;
        one_second = tick;
        model_step(k, tick);
        sb_q.push_back(model_out());
    endtask

    task automatic apply_rst(input logic [3:0] k);
        @(negedge clk);
        rst_n = 1'b0;
        key = k;
        one_second = 1'b0;
        model_reset();
        sb_q.push_back(model_out());
    endtask

    task automatic do_reset();
        repeat (2) apply_rst(4'hF);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: outputs are presented every cycle, so one expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("key_buffer", key_buffer, e.kb);
                check("show_a", 16'(show_a), 16'(e.sa));
                check("show_new_time", 16'(show_new_time), 16'(e.snt));
                check("load_new_a", 16'(load_new_a), 16'(e.lda));
                check("load_new_c", 16'(load_new_c), 16'(e.ldc));
            end
        end
    end

    initial begin
        logic [3:0] seq_a[] = '{4'h1, 4'hF, 4'h2, 4'hF, 4'h3, 4'hF, 4'h0, 4'hF, 4'hA, 4'hF, 4'hF};
        logic [3:0] seq_c[] = '{4'h5, 4'hF, 4'h9, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF};
        logic [3:0] k;
        do_reset();
        repeat (5) apply(4'hF);
        foreach (seq_a[i]) apply(seq_a[i]);
        foreach (seq_c[i]) apply(seq_c[i]);
        repeat (3) apply(4'hA);
        repeat (2) apply(4'hF);
        for (int d = 1; d <= 6; d++) begin
            apply(4'(d));
            apply(4'hF);
        end
        apply(4'hD);
        apply(4'hB);
        apply(4'hF);
        // Timeout walk (no effect on state unless the timeout is built).
        apply(4'h7);
        apply(4'hF);
        for (int t = 0; t < TS; t++) begin
            apply(4'hF, 1'b1);
            apply(4'hF);
        end
        apply(4'h8, 1'b1);
        apply(4'hF);
        apply(4'hE, 1'b1);
        apply(4'hF);

        do_reset();
        for (int n = 0; n < 400; n++) begin
            k = ($urandom_range(0, 9) < 5) ? 4'hF : 4'($urandom_range(0, 15));
            apply(k, 1'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the strobe cycle.
        do_reset();
        apply(4'h4);
        apply(4'hF);
        apply(4'hA);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_strobe_a", 16'(load_new_a), 16'h0);
        check("rst_buffer", key_buffer, 16'h0000);
        model_reset();
        apply_rst(4'hA);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'hF);
        apply(4'h9);
        apply(4'hF);
        apply(4'hB);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_strobe_c", 16'(load_new_c), 16'h0);
        model_reset();
        apply_rst(4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) apply(4'hF);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 16'(sb_q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
